seq_alu_exec: RTL and testbench



---
 rtl/seq_alu_exec.sv | 204 ++++++++++++++++++++
 tb/tb_seq_alu_exec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_exec.sv
// -----------------------------------------------------------------------------
// seq_alu_exec
//
// Multi-cycle execute unit placed between register read and writeback/branch
// resolution. It accepts one operation per in_valid/in_ready handshake and
// returns a registered result plus zero flag on an out_valid/out_ready
// handshake.
//
// Shifts are iterative by default: one bit per cycle, n cycles for a shift by
// n. All other operations, illegal codes and zero-distance shifts finish in
// one cycle.
//
// Build option (macro SEQ_ALU_FAST_SHIFT_EN):
//   When defined, shifts use a single-cycle barrel shifter and take the same
//   latency-1 path as every other operation. The SHIFT state is then never
//   entered and busy stays low. Results are bit-identical in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation request valid
//   in_ready   unit can accept a request (state == IDLE)
//   alu_ctrl   0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed),
//              0101 SLL, 0110 SRL, 0111 SRA; all other codes are illegal
//   op_a       operand A
//   op_b       operand B; the low SHAMT_W bits are the shift amount
//   out_valid  result valid (state == DONE)
//   out_ready  consumer accepts the result
//   result     operation result
//   zero       high when result == 0; meaningful only while out_valid = 1
//   busy       high while an iterative shift is in progress
// -----------------------------------------------------------------------------
module seq_alu_exec #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          alu_ctrl,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                zero,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;

    // Shift kind is the low two bits of the shift opcode.
    localparam logic [1:0] KIND_SLL = 2'b01;
    localparam logic [1:0] KIND_SRL = 2'b10;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [1:0]          state_reg, state_next;
    logic [XLEN-1:0]     result_reg, result_next;
    logic                zero_reg, zero_next;
    logic [SHAMT_W-1:0]  cnt_reg, cnt_next;
    logic [1:0]          kind_reg, kind_next;

    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift;
    logic [XLEN-1:0]     shift_full;
    logic [XLEN-1:0]     alu_value;
    logic [XLEN-1:0]     sll_step, srl_step, sra_step, shift_step;

    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                      (alu_ctrl == OP_SRA);

    // shift_full is what a shift produces on the single-cycle path. In the
    // iterative build that path is only taken for shamt == 0, so it is op_a.
`ifdef SEQ_ALU_FAST_SHIFT_EN
    localparam bit ITERATIVE = 1'b0;
    always_comb begin
        case (alu_ctrl[1:0])
            KIND_SLL: shift_full = op_a << shamt;
            KIND_SRL: shift_full = op_a >> shamt;
            default:  shift_full = $signed(op_a) >>> shamt;
        endcase
    end
`else
    localparam bit ITERATIVE = 1'b1;
    assign shift_full = op_a;
`endif

    // Single-cycle result for everything that does not iterate.
    always_comb begin
        alu_value = '0;
        case (alu_ctrl)
            OP_ADD: alu_value = op_a + op_b;
            OP_SUB: alu_value = op_a - op_b;
            OP_AND: alu_value = op_a & op_b;
            OP_OR:  alu_value = op_a | op_b;
            OP_SLT: alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL, OP_SRL, OP_SRA: alu_value = shift_full;
            default: alu_value = '0;
        endcase
    end

    // One-bit shift steps of the held result, built bit by bit.
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign sll_step[gi] = 1'b0;
            end else begin : g_nlsb
                assign sll_step[gi] = result_reg[gi-1];
            end
            if (gi == XLEN-1) begin : g_msb
                assign srl_step[gi] = 1'b0;
                assign sra_step[gi] = result_reg[XLEN-1];
            end else begin : g_nmsb
                assign srl_step[gi] = result_reg[gi+1];
                assign sra_step[gi] = result_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        case (kind_reg)
            KIND_SLL: shift_step = sll_step;
            KIND_SRL: shift_step = srl_step;
            default:  shift_step = sra_step;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        cnt_next    = cnt_reg;
        kind_next   = kind_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    if (ITERATIVE && is_shift && (shamt != '0)) begin
                        state_next  = ST_SHIFT;
                        result_next = op_a;
                        zero_next   = 1'b0;
                        cnt_next    = shamt;
                        kind_next   = alu_ctrl[1:0];
                    end else begin
                        state_next  = ST_DONE;
                        result_next = alu_value;
                        zero_next   = (alu_value == '0);
                    end
                end
            end
            ST_SHIFT: begin
                result_next = shift_step;
                cnt_next    = cnt_reg - CNT_ONE;
                // Zero flag is captured together with the last shift step.
                if (cnt_reg == CNT_ONE) begin
                    state_next = ST_DONE;
                    zero_next  = (shift_step == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            cnt_reg    <= '0;
            kind_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            cnt_reg    <= cnt_next;
            kind_reg   <= kind_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_SHIFT);
    assign result    = result_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_seq_alu_exec.sv
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    seq_alu_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
        int          busy_cycles;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic int lat_of(input logic [3:0] c, input logic [31:0] b);
`ifdef SEQ_ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    // Reference model for the randomised section.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b[4:0]);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return (sa < sb) ? 32'd1 : 32'd0;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one op, wait for the result, optionally hold out_ready low for
    // 'hold' cycles while a junk request is presented, then retire it.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic z, input string name,
                          input int hold);
        exp_t e;
        int cyc;
        int bcyc;
        logic [31:0] held;
        @(posedge clk); #1;
        check({name, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs: they must only be sampled at accept.
        op_a = $urandom; op_b = $urandom; alu_ctrl = 4'($urandom_range(0, 15));
        e.res = res; e.z = z; e.lat = lat_of(c, b); e.busy_cycles = lat_of(c, b) - 1;
        e.name = name;
        sb_q.push_back(e);
        cyc = 1; bcyc = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            cyc++;
        end
        e = sb_q.pop_front();
        check({e.name, ".out_valid"}, 32'(out_valid), 32'd1);
        check({e.name, ".result"}, result, e.res);
        check({e.name, ".zero"}, 32'(zero), 32'(e.z));
        check({e.name, ".latency"}, 32'(cyc), 32'(e.lat));
        check({e.name, ".busy_cycles"}, 32'(bcyc), 32'(e.busy_cycles));
        $display("op %-12s ctrl=%b a=%08h b=%08h -> result=%08h zero=%0d latency=%0d",
                 e.name, c, a, b, result, zero, cyc);
        held = result;
        for (int i = 0; i < hold; i++) begin
            alu_ctrl = 4'd1; op_a = 32'h1234; op_b = 32'h1; in_valid = 1'b1;
            @(posedge clk); #1;
            check({e.name, ".bp_out_valid"}, 32'(out_valid), 32'd1);
            check({e.name, ".bp_result"}, result, held);
            check({e.name, ".bp_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({e.name, ".post_out_valid"}, 32'(out_valid), 32'd0);
        check({e.name, ".post_in_ready"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            @(posedge clk); #1;
            check({e.name, ".junk_not_captured"}, 32'(out_valid | busy), 32'd0);
        end
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, "add_ovf"};
        vt[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, "sub_zero"};
        vt[2]  = '{4'h4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, "slt_neg"};
        vt[3]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, "illegal8"};
        vt[4]  = '{4'h7, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, "sra4"};
        vt[5]  = '{4'h6, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, "srl4"};
        vt[6]  = '{4'h5, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, "sll31"};
        vt[7]  = '{4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, "and"};
        vt[8]  = '{4'h3, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, "or"};
        vt[9]  = '{4'h4, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, "slt_false"};
        vt[10] = '{4'h6, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, "srl_shamt0"};
        vt[11] = '{4'h7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, "sra31"};
        vt[12] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, "illegalF"};
        vt[13] = '{4'h6, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, "srl_to_zero"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.zero", 32'(zero), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);

        for (int i = 0; i < 14; i++)
            run_op(vt[i].ctrl, vt[i].a, vt[i].b, vt[i].res, vt[i].z, vt[i].name, 0);

        // Backpressure: result held for 3 cycles, junk request ignored.
        run_op(4'h0, 32'd10, 32'd20, 32'd30, 1'b0, "add_bp", 3);

        // Reset in the middle of SLL by 20 aborts the operation.
        @(posedge clk); #1;
        alu_ctrl = 4'h5; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`ifndef SEQ_ALU_FAST_SHIFT_EN
        check("abort.busy_before", 32'(busy), 32'd1);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", result, 32'd0);
        $display("op abort_sll20 reset during shift, unit back to idle");
        run_op(4'h0, 32'd2, 32'd3, 32'd5, 1'b0, "add_after_rst", 0);

        // Randomised operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            rc = 4'($urandom_range(0, 9));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            if (i == 3) ra = rb;
            run_op(rc, ra, rb, model(rc, ra, rb), (model(rc, ra, rb) == 32'd0),
                   $sformatf("rand%0d", i), 0);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
